sdn_reg_responder: RTL and testbench

SDN_REG_RESPONDER -- requirements
Module: sdn_reg_responder

---
 rtl/sdn_reg_responder_pkg.sv | 35 +++
 rtl/sdn_reg_counter.sv | 35 +++
 rtl/sdn_reg_responder.sv | 115 +++++++++++
 tb/tb_sdn_reg_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdn_reg_responder_pkg.sv
// Shared constants, types and address decode for the SDN register-group responder.
package sdn_reg_responder_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_CNT = 4;

  localparam logic [31:0] SW_BASE  = 32'd0;
  localparam logic [31:0] HW_BASE  = 32'd4;
  localparam logic [31:0] CNT_BASE = 32'd8;
  localparam logic [31:0] CNT_END  = CNT_BASE + 32'(REG_CNT);

  localparam logic [DATA_W-1:0] UNMAPPED_RD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT_REQ_LOW
  } state_e;

  typedef enum logic [1:0] {
    RGN_SW,
    RGN_HW,
    RGN_CNT,
    RGN_NONE
  } region_e;

  // Bases are 4-word aligned, so the word index within a region is addr[1:0].
  function automatic region_e decode_region(input logic [31:0] addr);
    if (addr < HW_BASE)       return RGN_SW;
    else if (addr < CNT_BASE) return RGN_HW;
    else if (addr < CNT_END)  return RGN_CNT;
    else                      return RGN_NONE;
  endfunction

endpackage

// File: rtl/sdn_reg_counter.sv
// 32-bit event counter with software load and clear; a load wins over the same
// cycle's increment, while a clear keeps it so no event is lost.
module sdn_reg_counter
  import sdn_reg_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] ld_val_i,
  output logic [DATA_W-1:0] cnt_o
);

  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (clr_i) begin
      cnt_d = {{(DATA_W-1){1'b0}}, inc_i};
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sdn_reg_responder.sv
// Register-group responder: four software RW registers, four read-only hardware
// status words and four event counters behind a req/ack handshake.
module sdn_reg_responder
  import sdn_reg_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 8,
  parameter int unsigned CNT_CLR_ON_RD = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_req,
  input  logic                      reg_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]     reg_addr,
  input  logic [DATA_W-1:0]         reg_wr_data,
  output logic                      reg_ack,
  output logic [DATA_W-1:0]         reg_rd_data,
  output logic [REG_CNT*DATA_W-1:0] sw_regs,
  input  logic [REG_CNT*DATA_W-1:0] hw_regs,
  input  logic [REG_CNT-1:0]        cnt_inc
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rd_mux;
  logic [31:0]       addr_ext;
  region_e           region;
  logic [1:0]        idx;
  logic              accept, is_rd, is_wr;

  logic [DATA_W-1:0] sw_val  [REG_CNT];
  logic [DATA_W-1:0] cnt_val [REG_CNT];
  logic [REG_CNT-1:0] cnt_ld, cnt_clr;

  assign addr_ext = 32'(reg_addr);
  assign region   = decode_region(addr_ext);
  assign idx      = addr_ext[1:0];

  // The access is sampled and committed on the edge that leaves IDLE.
  assign accept = (state_q == ST_IDLE) && reg_req;
  assign is_rd  = accept && reg_rd_wr_L;
  assign is_wr  = accept && !reg_rd_wr_L;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (reg_req) state_d = ST_ACK;
      ST_ACK:          state_d = ST_WAIT_REQ_LOW;
      ST_WAIT_REQ_LOW: if (!reg_req) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Reset in the ACK cycle suppresses the ack so an aborted access is never seen.
  always_comb begin
    reg_ack     = (state_q == ST_ACK) && !reset;
    reg_rd_data = reg_ack ? rd_data_q : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (region)
      RGN_SW:   rd_mux = sw_val[idx];
      RGN_HW:   rd_mux = hw_regs[{idx, 5'b0} +: DATA_W];
      RGN_CNT:  rd_mux = cnt_val[idx];
      default:  rd_mux = UNMAPPED_RD;
    endcase
    rd_data_d = is_rd ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  generate
    for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_regs
      logic [DATA_W-1:0] sw_q, sw_d;
      logic              hit;

      assign hit = (idx == 2'(gi));

      always_comb begin
        sw_d = sw_q;
        if (is_wr && region == RGN_SW && hit) sw_d = reg_wr_data;
      end

      always_ff @(posedge clk) begin
        if (reset) sw_q <= '0;
        else       sw_q <= sw_d;
      end

      assign sw_val[gi]                     = sw_q;
      assign sw_regs[gi*DATA_W +: DATA_W]   = sw_q;

      assign cnt_ld[gi]  = is_wr && region == RGN_CNT && hit;
      assign cnt_clr[gi] = is_rd && region == RGN_CNT && hit && (CNT_CLR_ON_RD != 0);

      sdn_reg_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (cnt_inc[gi]),
        .clr_i    (cnt_clr[gi]),
        .ld_i     (cnt_ld[gi]),
        .ld_val_i (reg_wr_data),
        .cnt_o    (cnt_val[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sdn_reg_responder.sv
// Directed self-checking bench for sdn_reg_responder; a second instance with
// counter clear-on-read disabled runs in lockstep on the same stimulus.
module tb_sdn_reg_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         reg_req;
  logic         reg_rd_wr_L;
  logic [7:0]   reg_addr;
  logic [31:0]  reg_wr_data;
  logic [127:0] hw_regs;
  logic [3:0]   cnt_inc;

  logic         reg_ack, ack1;
  logic [31:0]  reg_rd_data, rd1;
  logic [127:0] sw_regs, sw1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdn_reg_responder #(.ADDR_WIDTH(8), .CNT_CLR_ON_RD(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .reg_req     (reg_req),
    .reg_rd_wr_L (reg_rd_wr_L),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_ack     (reg_ack),
    .reg_rd_data (reg_rd_data),
    .sw_regs     (sw_regs),
    .hw_regs     (hw_regs),
    .cnt_inc     (cnt_inc)
  );

  sdn_reg_responder #(.ADDR_WIDTH(8), .CNT_CLR_ON_RD(0)) dut_noclr (
    .clk         (clk),
    .reset       (reset),
    .reg_req     (reg_req),
    .reg_rd_wr_L (reg_rd_wr_L),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_ack     (ack1),
    .reg_rd_data (rd1),
    .sw_regs     (sw1),
    .hw_regs     (hw_regs),
    .cnt_inc     (cnt_inc)
  );

  // One access; inc is applied only on the sampling edge. lat = 0 means no ack within budget.
  task automatic access(input logic rd, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] inc, output int lat,
                        output logic [31:0] rdata, output logic [31:0] rdata1);
    reg_rd_wr_L = rd;
    reg_addr    = addr;
    reg_wr_data = wd;
    cnt_inc     = inc;
    reg_req     = 1'b1;
    lat = 0; rdata = '0; rdata1 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      cnt_inc = '0;
      if (reg_ack) begin
        lat = i; rdata = reg_rd_data; rdata1 = rd1;
        break;
      end
    end
    reg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("access %s addr=0x%02h wdata=0x%08h lat=%0d rdata=0x%08h rdata_noclr=0x%08h",
             rd ? "RD" : "WR", addr, wd, lat, rdata, rdata1);
  endtask

  task automatic test_reset();
    int lat; logic [31:0] r, r1;
    reset = 1'b1; reg_req = 0; reg_rd_wr_L = 1; reg_addr = 0; reg_wr_data = 0; cnt_inc = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (reg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", reg_ack); end
    n_checks++; if (reg_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00000000", reg_rd_data); end
    n_checks++; if (sw_regs !== 128'h0) begin n_fail++; $display("FAIL reset_sw_regs: got %h expected 0", sw_regs); end
    reset = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 8'd11, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_cnt3: got %h expected 00000000", r); end
  endtask

  task automatic test_sw_rw();
    int lat; logic [31:0] r, r1;
    access(1'b0, 8'd1, 32'h12345678, 4'h0, lat, r, r1);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL wr_latency: got %0d expected 1", lat); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL wr_rd_data: got %h expected 00000000", r); end
    n_checks++; if (sw_regs !== {64'h0, 32'h12345678, 32'h0}) begin n_fail++; $display("FAIL sw_reg1_out: got %h expected %h", sw_regs, {64'h0, 32'h12345678, 32'h0}); end
    access(1'b1, 8'd1, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rd_latency: got %0d expected 1", lat); end
    n_checks++; if (r !== 32'h12345678) begin n_fail++; $display("FAIL sw_reg1_read: got %h expected 12345678", r); end
    access(1'b0, 8'd3, 32'hA0B0C0D0, 4'h0, lat, r, r1);
    n_checks++; if (sw_regs[127:96] !== 32'hA0B0C0D0) begin n_fail++; $display("FAIL sw_reg3_out: got %h expected a0b0c0d0", sw_regs[127:96]); end
    access(1'b1, 8'd3, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'hA0B0C0D0) begin n_fail++; $display("FAIL sw_reg3_read: got %h expected a0b0c0d0", r); end
  endtask

  task automatic test_unmapped_hw();
    int lat; logic [31:0] r, r1;
    access(1'b1, 8'h3F, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL unmapped_3f: got %h expected deadbeef", r); end
    access(1'b1, 8'h0C, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL unmapped_0c: got %h expected deadbeef", r); end
    access(1'b0, 8'd5, 32'h55555555, 4'h0, lat, r, r1);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL hw_wr_ack: got lat %0d expected 1", lat); end
    access(1'b1, 8'd5, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'hCAFE0001) begin n_fail++; $display("FAIL hw_reg1_read: got %h expected cafe0001", r); end
    access(1'b1, 8'd7, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'h0BAD0003) begin n_fail++; $display("FAIL hw_reg3_read: got %h expected 0bad0003", r); end
    access(1'b0, 8'h20, 32'h77777777, 4'h0, lat, r, r1);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unmapped_wr_ack: got lat %0d expected 1", lat); end
  endtask

  task automatic test_counter_clr();
    int lat; logic [31:0] r, r1;
    cnt_inc = 4'b0100;
    repeat (10) @(posedge clk);
    #1; cnt_inc = '0;
    access(1'b1, 8'd10, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'd10) begin n_fail++; $display("FAIL cnt2_first_read: got %h expected 0000000a", r); end
    n_checks++; if (r1 !== 32'd10) begin n_fail++; $display("FAIL cnt2_first_read_noclr: got %h expected 0000000a", r1); end
    access(1'b1, 8'd10, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL cnt2_cleared: got %h expected 00000000", r); end
    n_checks++; if (r1 !== 32'd10) begin n_fail++; $display("FAIL cnt2_kept_noclr: got %h expected 0000000a", r1); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] r, r1;
    access(1'b0, 8'd8, 32'hFFFFFFFE, 4'h0, lat, r, r1);
    cnt_inc = 4'b0001;
    repeat (3) @(posedge clk);
    #1; cnt_inc = '0;
    access(1'b1, 8'd8, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL cnt0_wrap: got %h expected 00000001", r); end
    n_checks++; if (r1 !== 32'd1) begin n_fail++; $display("FAIL cnt0_wrap_noclr: got %h expected 00000001", r1); end
  endtask

  task automatic test_collision();
    int lat; logic [31:0] r, r1;
    access(1'b0, 8'd9, 32'd7, 4'b0010, lat, r, r1);
    access(1'b1, 8'd9, 32'h0, 4'b0010, lat, r, r1);
    n_checks++; if (r !== 32'd7) begin n_fail++; $display("FAIL cnt1_load_drops_inc: got %h expected 00000007", r); end
    n_checks++; if (r1 !== 32'd7) begin n_fail++; $display("FAIL cnt1_load_noclr: got %h expected 00000007", r1); end
    access(1'b1, 8'd9, 32'h0, 4'h0, lat, r, r1);
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL cnt1_clear_keeps_inc: got %h expected 00000001", r); end
    n_checks++; if (r1 !== 32'd8) begin n_fail++; $display("FAIL cnt1_inc_noclr: got %h expected 00000008", r1); end
  endtask

  task automatic test_back_to_back();
    int acks;
    int first_lat;
    reg_rd_wr_L = 1'b1; reg_addr = 8'd4; reg_req = 1'b1; acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (reg_ack) acks++;
    end
    $display("held request 20 cycles: acks=%0d", acks);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL held_req_acks: got %0d expected 1", acks); end
    reg_req = 1'b0;
    @(posedge clk); #1;
    reg_req = 1'b1; acks = 0; first_lat = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (reg_ack) begin
        acks++;
        if (first_lat == 0) first_lat = i;
      end
    end
    $display("re-request after 1 low cycle: acks=%0d lat=%0d", acks, first_lat);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL second_req_acks: got %0d expected 1", acks); end
    n_checks++; if (first_lat !== 1) begin n_fail++; $display("FAIL second_req_latency: got %0d expected 1", first_lat); end
    reg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    reg_rd_wr_L = 1'b0; reg_addr = 8'd2; reg_wr_data = 32'hA5A5A5A5; reg_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++; if (reg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_in_ack_no_ack: got %b expected 0", reg_ack); end
    @(posedge clk); #1;
    $display("reset during ACK of write 0xa5a5a5a5 to addr 2: sw_reg2=0x%08h", sw_regs[95:64]);
    n_checks++; if (sw_regs[95:64] !== 32'h0) begin n_fail++; $display("FAIL reset_in_ack_sw2: got %h expected 00000000", sw_regs[95:64]); end
    n_checks++; if (reg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_in_ack_ack_low: got %b expected 0", reg_ack); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (reg_ack !== 1'b1) begin n_fail++; $display("FAIL held_req_after_reset_ack: got %b expected 1", reg_ack); end
    reg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (sw_regs[95:64] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL held_req_after_reset_sw2: got %h expected a5a5a5a5", sw_regs[95:64]); end
  endtask

  initial begin
    hw_regs = {32'h0BAD0003, 32'h0BAD0002, 32'hCAFE0001, 32'h0BAD0000};
    test_reset();
    test_sw_rw();
    test_unmapped_hw();
    test_counter_clr();
    test_wrap();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
